// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC3 fetch stage.
// Covers the reset pc, the fetch FSM states and the buffered (pc, instruction) entry.
package lc3_pkg;

    localparam logic [15:0] LC3_BASE_ADDR = 16'h3000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    // Instruction address arithmetic wraps modulo 2^16.
    function automatic logic [15:0] next_pc(input logic [15:0] p);
        return p + 16'd1;
    endfunction

endpackage

// File: rtl/lc3_fetch_unit_if.sv
// Instruction-memory request/response and decode handshake signals of the fetch stage.
// master = fetch unit, slave = memory driver plus decode.
interface lc3_fetch_unit_if;

    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [15:0] dec_npc;

    modport master (
        output pc, instrmem_rd, dec_valid, dec_instr, dec_pc, dec_npc,
        input  Instr_dout, complete_instr, dec_ready
    );

    modport slave (
        input  pc, instrmem_rd, dec_valid, dec_instr, dec_pc, dec_npc,
        output Instr_dout, complete_instr, dec_ready
    );

endinterface

// File: rtl/lc3_fetch_fifo.sv
// Small fetch buffer of (pc, instr) entries with push, pop and flush.
// The head is read combinationally from storage; a flush in the same cycle as a push drops the push.
module lc3_fetch_fifo
    import lc3_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t         mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Empty buffer presents zeros so decode sees clean values after reset/flush.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= entry_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: issues one instruction-memory request at a time, buffers returned words
// for decode, and on a branch redirect flushes and restarts at the target (draining any open request).
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = LC3_BASE_ADDR,
    parameter int          DEPTH     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               br_taken,
    input  logic [15:0]        taddr,
    lc3_fetch_unit_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e   state_q, state_d;
    logic [15:0]    pc_q, pc_d;
    logic [15:0]    target_q, target_d;
    logic           mem_rd;
    logic           accept;
    logic           push;
    logic           pop;
    fetch_entry_t   head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_full;

    // A DRAIN request must stay asserted until the abandoned access completes.
    assign mem_rd = ((state_q == FETCH) && (fifo_count < CW'(DEPTH)) && !fifo_full)
                  || (state_q == DRAIN);
    assign accept = mem_rd && bus.complete_instr;
    assign pop    = !fifo_empty && bus.dec_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (br_taken) pc_d = taddr;
            end
            FETCH: begin
                if (br_taken) begin
                    if (mem_rd && !accept) begin
                        target_d = taddr;
                        state_d  = DRAIN;
                    end else begin
                        pc_d = taddr;
                    end
                end else if (accept) begin
                    push = 1'b1;
                    pc_d = next_pc(pc_q);
                end
            end
            DRAIN: begin
                if (accept) begin
                    pc_d    = br_taken ? taddr : target_q;
                    state_d = FETCH;
                end else if (br_taken) begin
                    target_d = taddr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= BASE_ADDR;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    lc3_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .entry_i ('{pc: pc_q, instr: bus.Instr_dout}),
        .pop_i   (pop),
        .flush_i (br_taken),
        .head_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.pc          = pc_q;
    assign bus.instrmem_rd = mem_rd;
    assign bus.dec_valid   = !fifo_empty;
    assign bus.dec_instr   = head.instr;
    assign bus.dec_pc      = head.pc;
    assign bus.dec_npc     = next_pc(head.pc);

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: reset, streaming, back-pressure, slow memory,
// redirects (idle, outstanding, wrap) and asynchronous reset during DRAIN.
module tb_lc3_fetch_unit;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    lc3_fetch_unit_if bus ();

    lc3_fetch_unit #(
        .BASE_ADDR (16'h3000),
        .DEPTH     (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .br_taken (br_taken),
        .taddr    (taddr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        br_taken           = 1'b0;
        bus.complete_instr = 1'b0;
        bus.dec_ready      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.Instr_dout     = '0;
        bus.complete_instr = 1'b0;
        bus.dec_ready      = 1'b0;

        // Reset values
        do_reset();
        check_val("rst_pc", 32'(bus.pc), 32'h3000);
        check_val("rst_rd", 32'(bus.instrmem_rd), 32'h0);
        check_val("rst_valid", 32'(bus.dec_valid), 32'h0);
        check_val("rst_instr", 32'(bus.dec_instr), 32'h0);
        check_val("rst_decpc", 32'(bus.dec_pc), 32'h0);

        // 1: streaming, first request on cycle 1, one-cycle latency to decode
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h1234;
        tick();
        check_val("t1_rd", 32'(bus.instrmem_rd), 32'h1);
        check_val("t1_pc", 32'(bus.pc), 32'h3000);
        check_val("t1_valid0", 32'(bus.dec_valid), 32'h0);
        tick();
        check_val("t1_valid", 32'(bus.dec_valid), 32'h1);
        check_val("t1_instr", 32'(bus.dec_instr), 32'h1234);
        check_val("t1_decpc", 32'(bus.dec_pc), 32'h3000);
        check_val("t1_npc", 32'(bus.dec_npc), 32'h3001);
        bus.Instr_dout = 16'h5678;

        // 2: back-pressure fills the buffer, then one pop resumes fetch
        tick();
        check_val("t2_rd_full", 32'(bus.instrmem_rd), 32'h0);
        check_val("t2_pc_hold", 32'(bus.pc), 32'h3002);
        check_val("t2_head", 32'(bus.dec_pc), 32'h3000);
        tick();
        check_val("t2_pc_hold2", 32'(bus.pc), 32'h3002);
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        check_val("t2_head2_pc", 32'(bus.dec_pc), 32'h3001);
        check_val("t2_head2_instr", 32'(bus.dec_instr), 32'h5678);
        check_val("t2_resume_rd", 32'(bus.instrmem_rd), 32'h1);
        check_val("t2_resume_pc", 32'(bus.pc), 32'h3002);

        // 3: memory completes after 3 wait cycles
        do_reset();
        bus.Instr_dout = 16'hABCD;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t3_pc_w%0d", i), 32'(bus.pc), 32'h3000);
            check_val($sformatf("t3_rd_w%0d", i), 32'(bus.instrmem_rd), 32'h1);
            tick();
        end
        check_val("t3_pc_w3", 32'(bus.pc), 32'h3000);
        check_val("t3_valid_w3", 32'(bus.dec_valid), 32'h0);
        bus.complete_instr = 1'b1;
        tick();
        bus.complete_instr = 1'b0;
        check_val("t3_valid", 32'(bus.dec_valid), 32'h1);
        check_val("t3_instr", 32'(bus.dec_instr), 32'hABCD);
        check_val("t3_pc_next", 32'(bus.pc), 32'h3001);
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        check_val("t3_one_push", 32'(bus.dec_valid), 32'h0);

        // 4: redirect with idle memory and full buffer
        do_reset();
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h1111;
        tick();
        tick();
        tick();
        check_val("t4_rd_idle", 32'(bus.instrmem_rd), 32'h0);
        check_val("t4_valid", 32'(bus.dec_valid), 32'h1);
        bus.complete_instr = 1'b0;
        br_taken = 1'b1;
        taddr    = 16'h3050;
        tick();
        br_taken = 1'b0;
        check_val("t4_flushed", 32'(bus.dec_valid), 32'h0);
        check_val("t4_pc", 32'(bus.pc), 32'h3050);
        check_val("t4_rd", 32'(bus.instrmem_rd), 32'h1);

        // 5: redirect while 3001 is outstanding -> DRAIN
        do_reset();
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h2222;
        tick();
        tick();
        bus.complete_instr = 1'b0;
        br_taken = 1'b1;
        taddr    = 16'h3050;
        tick();
        br_taken = 1'b0;
        check_val("t5_state", 32'(dut.state_q), 32'(DRAIN));
        check_val("t5_pc_hold", 32'(bus.pc), 32'h3001);
        check_val("t5_rd", 32'(bus.instrmem_rd), 32'h1);
        check_val("t5_flushed", 32'(bus.dec_valid), 32'h0);
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'hDEAD;
        tick();
        bus.complete_instr = 1'b0;
        check_val("t5_pc_target", 32'(bus.pc), 32'h3050);
        check_val("t5_discard", 32'(bus.dec_valid), 32'h0);
        check_val("t5_state2", 32'(dut.state_q), 32'(FETCH));
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h3333;
        tick();
        bus.complete_instr = 1'b0;
        check_val("t5_head_pc", 32'(bus.dec_pc), 32'h3050);
        check_val("t5_head_instr", 32'(bus.dec_instr), 32'h3333);

        // 6: redirect to FFFF with same-cycle completion, pc wraps
        do_reset();
        tick();
        br_taken           = 1'b1;
        taddr              = 16'hFFFF;
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h7777;
        tick();
        br_taken       = 1'b0;
        bus.Instr_dout = 16'h8888;
        check_val("t6_pc", 32'(bus.pc), 32'hFFFF);
        check_val("t6_discard", 32'(bus.dec_valid), 32'h0);
        tick();
        check_val("t6_head_pc", 32'(bus.dec_pc), 32'hFFFF);
        check_val("t6_npc_wrap", 32'(bus.dec_npc), 32'h0000);
        check_val("t6_pc_wrap", 32'(bus.pc), 32'h0000);
        bus.Instr_dout = 16'h9999;
        tick();
        bus.complete_instr = 1'b0;
        bus.dec_ready      = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        check_val("t6_head2_pc", 32'(bus.dec_pc), 32'h0000);
        check_val("t6_head2_instr", 32'(bus.dec_instr), 32'h9999);
        check_val("t6_head2_npc", 32'(bus.dec_npc), 32'h0001);

        // 7: asynchronous reset in the middle of DRAIN
        do_reset();
        bus.complete_instr = 1'b1;
        bus.Instr_dout     = 16'h4444;
        tick();
        tick();
        bus.complete_instr = 1'b0;
        br_taken = 1'b1;
        taddr    = 16'h3050;
        tick();
        br_taken = 1'b0;
        check_val("t7_pc_drain", 32'(bus.pc), 32'h3001);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t7_async_pc", 32'(bus.pc), 32'h3000);
        check_val("t7_async_rd", 32'(bus.instrmem_rd), 32'h0);
        check_val("t7_async_valid", 32'(bus.dec_valid), 32'h0);
        check_val("t7_async_state", 32'(dut.state_q), 32'(IDLE));
        bus.complete_instr = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        check_val("t7_rel_rd", 32'(bus.instrmem_rd), 32'h0);
        tick();
        check_val("t7_ignored", 32'(bus.dec_valid), 32'h0);
        check_val("t7_fetch_pc", 32'(bus.pc), 32'h3000);
        check_val("t7_fetch_rd", 32'(bus.instrmem_rd), 32'h1);
        tick();
        bus.complete_instr = 1'b0;
        check_val("t7_head_pc", 32'(bus.dec_pc), 32'h3000);
        check_val("t7_head_instr", 32'(bus.dec_instr), 32'h4444);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
